// File: rtl/mux_slave_arbiter.sv
// Two-master, one-slave round-robin arbiter for the req/ack bus.
// Grant is held for a whole transaction; read data is steered back to the master that owned the read.
module mux_slave_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_in,
  input  logic [ADDR_W-1:0] m0_addr_in,
  input  logic              m0_cmd_in,
  input  logic [DATA_W-1:0] m0_wdata_in,
  output logic              m0_ack_out,
  output logic [DATA_W-1:0] m0_rdata_out,
  input  logic              m1_req_in,
  input  logic [ADDR_W-1:0] m1_addr_in,
  input  logic              m1_cmd_in,
  input  logic [DATA_W-1:0] m1_wdata_in,
  output logic              m1_ack_out,
  output logic [DATA_W-1:0] m1_rdata_out,
  output logic              s_req_out,
  output logic [ADDR_W-1:0] s_addr_out,
  output logic              s_cmd_out,
  output logic [DATA_W-1:0] s_wdata_out,
  input  logic              s_ack_in,
  input  logic [DATA_W-1:0] s_rdata_in,
  output logic [1:0]        grant_out
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;
  logic   rd_pend, rd_owner;
  logic   gnt0, gnt1;
  logic   acked;

  assign gnt0  = (state == GNT0);
  assign gnt1  = (state == GNT1);
  assign acked = s_ack_in && (gnt0 || gnt1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      rd_pend  <= acked && !s_cmd_out;
      rd_owner <= gnt1;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        if (m0_req_in && m1_req_in) state_nxt = prio ? GNT1 : GNT0;
        else if (m0_req_in)         state_nxt = GNT0;
        else if (m1_req_in)         state_nxt = GNT1;
      end
      GNT0: begin
        if (s_ack_in) begin
          prio_nxt  = 1'b1;
          state_nxt = m1_req_in ? GNT1 : IDLE;
        end else if (!m0_req_in) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (s_ack_in) begin
          prio_nxt  = 1'b0;
          state_nxt = m0_req_in ? GNT0 : IDLE;
        end else if (!m1_req_in) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_req_out   = 1'b0;
    s_addr_out  = '0;
    s_cmd_out   = 1'b0;
    s_wdata_out = '0;
    if (gnt0) begin
      s_req_out   = m0_req_in;
      s_addr_out  = m0_addr_in;
      s_cmd_out   = m0_cmd_in;
      s_wdata_out = m0_wdata_in;
    end else if (gnt1) begin
      s_req_out   = m1_req_in;
      s_addr_out  = m1_addr_in;
      s_cmd_out   = m1_cmd_in;
      s_wdata_out = m1_wdata_in;
    end
  end

  assign m0_ack_out = s_ack_in && gnt0;
  assign m1_ack_out = s_ack_in && gnt1;
  assign grant_out  = {gnt1, gnt0};

  // Read return follows the registered owner, so it survives a same-cycle grant handover.
  assign m0_rdata_out = (rd_pend && !rd_owner) ? s_rdata_in : '0;
  assign m1_rdata_out = (rd_pend &&  rd_owner) ? s_rdata_in : '0;

endmodule

// File: tb/tb_mux_slave_arbiter.sv
// Randomized bench for mux_slave_arbiter against a transaction-level owner/priority model.
module tb_mux_slave_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              req   [2];
  logic [ADDR_W-1:0] addr  [2];
  logic              cmd   [2];
  logic [DATA_W-1:0] wdata [2];
  logic              ack   [2];
  logic [DATA_W-1:0] rdata [2];
  logic              s_req, s_cmd, s_ack;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [1:0]        grant;

  mux_slave_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_in(req[0]), .m0_addr_in(addr[0]), .m0_cmd_in(cmd[0]), .m0_wdata_in(wdata[0]),
    .m0_ack_out(ack[0]), .m0_rdata_out(rdata[0]),
    .m1_req_in(req[1]), .m1_addr_in(addr[1]), .m1_cmd_in(cmd[1]), .m1_wdata_in(wdata[1]),
    .m1_ack_out(ack[1]), .m1_rdata_out(rdata[1]),
    .s_req_out(s_req), .s_addr_out(s_addr), .s_cmd_out(s_cmd), .s_wdata_out(s_wdata),
    .s_ack_in(s_ack), .s_rdata_in(s_rdata), .grant_out(grant)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner -1 = nobody granted; rd_owner -1 = no read returning this cycle.
  int owner, prio, rd_owner;
  logic exp_ack [2];
  logic acked   [2];
  logic active  [2];
  bit   in_reset;

  task automatic model_reset();
    owner = -1; prio = 0; rd_owner = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".s_req"},  s_req,   0);
    check({tag, ".s_addr"}, s_addr,  0);
    check({tag, ".s_cmd"},  s_cmd,   0);
    check({tag, ".s_wd"},   s_wdata, 0);
    check({tag, ".grant"},  grant,   0);
    check({tag, ".ack0"},   ack[0],  0);
    check({tag, ".ack1"},   ack[1],  0);
    check({tag, ".rd0"},    rdata[0], 0);
    check({tag, ".rd1"},    rdata[1], 0);
  endtask

  task automatic check_outputs();
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic              e_cmd;
    logic [DATA_W-1:0] e_wd;
    e_req = 0; e_addr = '0; e_cmd = 0; e_wd = '0;
    if (owner >= 0) begin
      e_req = req[owner]; e_addr = addr[owner]; e_cmd = cmd[owner]; e_wd = wdata[owner];
    end
    check("s_req",   s_req,   e_req);
    check("s_addr",  s_addr,  e_addr);
    check("s_cmd",   s_cmd,   e_cmd);
    check("s_wdata", s_wdata, e_wd);
    check("grant",   grant,   (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
    for (int n = 0; n < 2; n++) begin
      exp_ack[n] = s_ack && (owner == n);
      check($sformatf("ack%0d", n), ack[n], exp_ack[n]);
      check($sformatf("rdata%0d", n), rdata[n], (rd_owner == n) ? s_rdata : '0);
    end
  endtask

  task automatic model_step();
    int other;
    rd_owner = (owner >= 0 && s_ack && !cmd[owner]) ? owner : -1;
    if (owner < 0) begin
      if (req[0] && req[1]) owner = prio;
      else if (req[0])      owner = 0;
      else if (req[1])      owner = 1;
    end else if (s_ack) begin
      other = 1 - owner;
      prio  = other;
      owner = req[other] ? other : -1;
    end else if (!req[owner]) begin
      owner = -1;
    end
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < 2; n++) begin
      if (acked[n]) active[n] = 0;
      if (!active[n]) begin
        if ($urandom_range(0, 1) == 0) begin
          active[n] = 1;
          addr[n]   = $urandom;
          cmd[n]    = $urandom_range(0, 1);
          wdata[n]  = $urandom;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        active[n] = 0;
      end
      req[n] = active[n];
    end
    if (owner >= 0 && req[owner]) s_ack = ($urandom_range(0, 2) == 0);
    else if (owner < 0)           s_ack = ($urandom_range(0, 7) == 0);
    else                          s_ack = 0;
    s_rdata = $urandom;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      req[n] = 0; addr[n] = '0; cmd[n] = 0; wdata[n] = '0;
      active[n] = 0; acked[n] = 0; exp_ack[n] = 0;
    end
    s_ack = 0; s_rdata = '0; in_reset = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_inputs();
      if (cyc == 1500 || cyc == 3100) begin
        #2 rst = 0;
        #1 check_all_zero("async_rst");
        model_reset();
        in_reset = 1;
      end
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      if (!in_reset) model_step();
      for (int n = 0; n < 2; n++) acked[n] = exp_ack[n];
      #1;
      if (in_reset) begin
        rst = 1;
        in_reset = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
